// File: rtl/type_handle_registry_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : type_handle_registry_arb                                    |
// | Purpose  : Type-handle registry shared by NUM_REQ requesters. Each     |
// |            request carries a key; an existing key returns its stable   |
// |            ID, a new key is given the next free ID (singleton table).  |
// |            Round-robin arbiter in front of a scan/allocate FSM that    |
// |            walks the key table one entry per cycle.                    |
// | Ports    : clk, rst_n           clock / async active-low reset         |
// |            req_valid, req_key   per-requester request and key          |
// |            req_ready            one-hot grant pulse (key latched)      |
// |            rsp_valid/rsp_ready  response handshake                     |
// |            rsp_req, rsp_id      answered requester, type ID            |
// |            rsp_new, rsp_full    allocated here / table full            |
// |            clear                flush the registry (sampled in IDLE)   |
// |            count, busy          registered entries / FSM not IDLE      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module type_handle_registry_arb #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = 32,
  parameter int DEPTH   = 16,
  parameter int ID_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*KEY_W-1:0]   req_key,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_req,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_new,
  output logic                       rsp_full,
  input  logic                       clear,
  output logic [ID_W:0]              count,
  output logic                       busy
);

  localparam int            REQ_W   = $clog2(NUM_REQ);
  localparam logic [ID_W:0] C_DEPTH = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0] C_ONE   = (ID_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [REQ_W-1:0]   last_q, last_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [ID_W:0]      idx_q, idx_d;
  logic [ID_W:0]      count_q, count_d;
  logic [REQ_W-1:0]   rsp_req_q, rsp_req_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_new_q, rsp_new_d;
  logic               rsp_full_q, rsp_full_d;
  // High for the one IDLE cycle that follows a completed response: the
  // response outputs fall there and arbitration resumes the cycle after,
  // giving the 4-cycle minimum grant-to-grant spacing.
  logic               turn_q, turn_d;

  logic [KEY_W-1:0]   table_q [DEPTH];
  logic               tbl_we;

  logic               grant_found;
  logic [REQ_W-1:0]   grant_idx;
  logic [KEY_W-1:0]   grant_key;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int c;
    c           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = int'(last_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!grant_found && req_valid[REQ_W'(c)]) begin
        grant_found = 1'b1;
        grant_idx   = REQ_W'(c);
      end
    end
  end

  assign grant_key = req_key[int'(grant_idx)*KEY_W +: KEY_W];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    key_d      = key_q;
    idx_d      = idx_q;
    count_d    = count_q;
    rsp_req_d  = rsp_req_q;
    rsp_id_d   = rsp_id_q;
    rsp_new_d  = rsp_new_q;
    rsp_full_d = rsp_full_q;
    turn_d     = 1'b0;
    tbl_we     = 1'b0;
    req_ready  = '0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          // Flush has priority over any pending request this cycle.
          count_d = '0;
        end else if (grant_found && !turn_q) begin
          req_ready[grant_idx] = 1'b1;
          key_d     = grant_key;
          idx_d     = '0;
          last_d    = grant_idx;
          rsp_req_d = grant_idx;
          state_d   = S_SCAN;
        end
      end

      S_SCAN: begin
        if (idx_q < count_q) begin
          if (table_q[idx_q[ID_W-1:0]] == key_q) begin
            rsp_id_d   = idx_q[ID_W-1:0];
            rsp_new_d  = 1'b0;
            rsp_full_d = 1'b0;
            state_d    = S_RESP;
          end else begin
            idx_d = idx_q + C_ONE;
          end
        end else if (count_q < C_DEPTH) begin
          tbl_we     = 1'b1;
          rsp_id_d   = count_q[ID_W-1:0];
          rsp_new_d  = 1'b1;
          rsp_full_d = 1'b0;
          count_d    = count_q + C_ONE;
          state_d    = S_RESP;
        end else begin
          rsp_id_d   = '0;
          rsp_new_d  = 1'b0;
          rsp_full_d = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          turn_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= REQ_W'(NUM_REQ - 1);
      key_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      rsp_req_q  <= '0;
      rsp_id_q   <= '0;
      rsp_new_q  <= 1'b0;
      rsp_full_q <= 1'b0;
      turn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      rsp_req_q  <= rsp_req_d;
      rsp_id_q   <= rsp_id_d;
      rsp_new_q  <= rsp_new_d;
      rsp_full_q <= rsp_full_d;
      turn_q     <= turn_d;
    end
  end

  // Table storage needs no reset: entries at index >= count are never read.
  always_ff @(posedge clk) begin
    if (tbl_we) table_q[count_q[ID_W-1:0]] <= key_q;
  end

  // Response fields are only presented while the response is valid.
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_req   = rsp_valid ? rsp_req_q  : '0;
  assign rsp_id    = rsp_valid ? rsp_id_q   : '0;
  assign rsp_new   = rsp_valid ? rsp_new_q  : 1'b0;
  assign rsp_full  = rsp_valid ? rsp_full_q : 1'b0;
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_type_handle_registry_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_type_handle_registry_arb                                 |
// | Purpose  : Scoreboard bench for type_handle_registry_arb. A reference  |
// |            model (key queue + round-robin pick) predicts each grant    |
// |            and response; a monitor compares on every DUT response.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_type_handle_registry_arb;

  localparam int NUM_REQ = 4;
  localparam int KEY_W   = 32;
  localparam int DEPTH   = 16;
  localparam int ID_W    = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*KEY_W-1:0] req_key;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_req;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_new;
  logic                     rsp_full;
  logic                     clear;
  logic [ID_W:0]            count;
  logic                     busy;

  always #5 clk = ~clk;

  type_handle_registry_arb #(
    .NUM_REQ(NUM_REQ), .KEY_W(KEY_W), .DEPTH(DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_key(req_key),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_req(rsp_req), .rsp_id(rsp_id), .rsp_new(rsp_new), .rsp_full(rsp_full),
    .clear(clear), .count(count), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int req;
    int id;
    bit isnew;
    bit full;
    int due;
    int cnt;
  } exp_t;

  logic [KEY_W-1:0]   m_tab[$];
  int                 m_last = NUM_REQ - 1;
  bit                 txn_open = 0;
  bit                 in_rsp = 0;
  exp_t               sbq[$];
  exp_t               cur;
  int                 hs_cycle = -100;
  int                 grant_log[$];
  logic [NUM_REQ-1:0] granted_last = '0;

  function automatic int rr_pick(logic [NUM_REQ-1:0] v, int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: observes grants and responses, runs the model, compares.
  always @(negedge clk) begin : mon
    int g;
    int m;
    exp_t e;
    logic [KEY_W-1:0] k;
    cycle++;
    if (!rst_n) begin
      check("reset_rsp_valid", 64'(rsp_valid), 0);
      check("reset_count", 64'(count), 0);
      check("reset_busy", 64'(busy), 0);
      m_tab.delete();
      sbq.delete();
      m_last       = NUM_REQ - 1;
      txn_open     = 0;
      in_rsp       = 0;
      granted_last = '0;
      hs_cycle     = -100;
    end else begin
      check("busy", 64'(busy), 64'(txn_open));
      if (!txn_open) check("count_idle", 64'(count), 64'(m_tab.size()));
      if (clear && !txn_open) m_tab.delete();
      if (cycle == hs_cycle + 1) check("turnaround_no_grant", 64'(req_ready), 0);
      if (cycle == hs_cycle + 2 && req_valid != 0 && !clear)
        check("grant_spacing", 64'(req_ready != 0), 1);

      granted_last = req_ready;
      if (req_ready != 0) begin
        g = rr_pick(req_valid, m_last);
        check("grant_no_clear", 64'(clear), 0);
        check("grant_when_idle", 64'(txn_open), 0);
        if (g < 0) begin
          fail_now("grant_without_request");
        end else begin
          check("grant_idx", 64'(req_ready), 64'(1) << g);
          k = req_key[g*KEY_W +: KEY_W];
          m = -1;
          for (int j = 0; j < m_tab.size(); j++)
            if (m < 0 && m_tab[j] == k) m = j;
          e.req = g;
          if (m >= 0) begin
            e.id = m; e.isnew = 0; e.full = 0; e.due = cycle + m + 2;
          end else if (m_tab.size() < DEPTH) begin
            e.id = m_tab.size(); e.isnew = 1; e.full = 0;
            e.due = cycle + m_tab.size() + 2;
            m_tab.push_back(k);
          end else begin
            e.id = 0; e.isnew = 0; e.full = 1; e.due = cycle + DEPTH + 2;
          end
          e.cnt = m_tab.size();
          sbq.push_back(e);
          grant_log.push_back(g);
          m_last   = g;
          txn_open = 1;
        end
      end

      if (rsp_valid) begin
        if (!in_rsp) begin
          if (sbq.size() == 0) begin
            fail_now("rsp_unexpected");
          end else begin
            cur    = sbq.pop_front();
            in_rsp = 1;
            check("rsp_latency", 64'(cycle), 64'(cur.due));
            check("count_at_rsp", 64'(count), 64'(cur.cnt));
          end
        end
        if (in_rsp) begin
          check("rsp_req", 64'(rsp_req), 64'(cur.req));
          check("rsp_id", 64'(rsp_id), 64'(cur.id));
          check("rsp_new", 64'(rsp_new), 64'(cur.isnew));
          check("rsp_full", 64'(rsp_full), 64'(cur.full));
          check("no_grant_in_rsp", 64'(req_ready), 0);
          if (rsp_ready) begin
            in_rsp   = 0;
            txn_open = 0;
            hs_cycle = cycle;
          end
        end
      end else if (in_rsp) begin
        fail_now("rsp_dropped_without_ready");
        in_rsp = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit auto_ready = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~granted_last;
    if (auto_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic raise(int i, logic [KEY_W-1:0] k);
    req_valid[i] = 1'b1;
    req_key[i*KEY_W +: KEY_W] = k;
  endtask

  task automatic wait_quiet(int budget);
    int n;
    n = 0;
    while ((req_valid != 0 || txn_open || sbq.size() != 0 || in_rsp) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("wait_quiet_timeout");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 1, 3};
    rst_n = 1'b0; req_valid = '0; req_key = '0; clear = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Empty table, first key -> ID 0, new.
    raise(0, 32'hA5A5_0001);
    wait_quiet(50);
    check("t1_count", 64'(count), 1);

    // Three more keys, then the first key again from requester 2.
    raise(1, 32'h1111_0001); wait_quiet(50);
    raise(3, 32'h1111_0002); wait_quiet(50);
    raise(0, 32'h1111_0003); wait_quiet(50);
    raise(2, 32'hA5A5_0001); wait_quiet(50);
    check("t2_count", 64'(count), 4);

    // From reset all four at once, then 1 and 3: order 0,1,2,3,1,3.
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) raise(i, 32'h2222_0000 + i);
    wait_quiet(100);
    raise(1, 32'h2222_0010);
    raise(3, 32'h2222_0030);
    wait_quiet(100);
    check("t3_order_len", 64'(grant_log.size()), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("t3_order", 64'(grant_log[i]), 64'(exp_order[i]));

    // Fill the table, then one more new key (full), then a hit.
    clear = 1'b1; tick(); clear = 1'b0; tick();
    check("t4_cleared", 64'(count), 0);
    for (int j = 0; j < DEPTH; j++) begin
      raise(j % NUM_REQ, 32'hB000_0000 + j);
      wait_quiet(100);
    end
    raise(1, 32'hC0DE_0017); wait_quiet(100);
    raise(2, 32'hB000_0007); wait_quiet(100);
    check("t4_count_full", 64'(count), 16);

    // Response back-pressure with another request waiting.
    rsp_ready = 1'b0;
    raise(0, 32'hB000_0005);
    raise(1, 32'hB000_000C);
    for (int n = 0; n < 100 && !rsp_valid; n++) tick();
    if (!rsp_valid) fail_now("t5_no_rsp");
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_quiet(100);

    // clear raised during a long SCAN only acts once back in IDLE.
    raise(0, 32'hDEAD_0001);
    repeat (3) tick();
    clear = 1'b1;
    tick();
    check("t6_count_in_scan", 64'(count), 16);
    for (int n = 0; n < 100 && txn_open; n++) tick();
    tick(); tick();
    clear = 1'b0;
    tick();
    check("t6_count_cleared", 64'(count), 0);
    raise(2, 32'hDEAD_0002);
    wait_quiet(50);

    // Reset in the middle of a SCAN: no response, count back to 0.
    for (int j = 0; j < 5; j++) begin
      raise(j % NUM_REQ, 32'hE000_0000 + j);
      wait_quiet(50);
    end
    raise(3, 32'hE000_00FF);
    tick(); tick();
    rst_n = 1'b0; req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (25) tick();
    check("t7_count_after_reset", 64'(count), 0);
    check("t7_no_rsp", 64'(rsp_valid), 0);

    // Randomised traffic from a key pool larger than the table.
    auto_ready = 1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          raise(i, 32'h5000_0000 + 32'h0001_0003 * $urandom_range(0, 23));
        else if (req_valid[i] && $urandom_range(0, 63) == 0)
          req_valid[i] = 1'b0;
      end
      clear = ($urandom_range(0, 199) == 0);
      tick();
    end
    clear = 1'b0;
    wait_quiet(400);
    auto_ready = 0;
    rsp_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/type_handle_registry_arb.md
Name: type_handle_registry_arb

Overview:
- Hardware type-handle registry shared by NUM_REQ requesters; enforces singleton semantics.
- Each requester presents a type key and receives a unique, stable type ID.
- Existing key returns its ID; a new key is allocated the next free ID.
- Round-robin arbiter plus a scan/allocate FSM over a DEPTH-entry key table; serves one request at a time.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
KEY_W, 32, type key width
DEPTH, 16, registry entries (power of 2)
ID_W, $clog2(DEPTH), type ID width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_key  in  NUM_REQ*KEY_W  per-requester key, requester i at [i*KEY_W +: KEY_W]
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_req  out  $clog2(NUM_REQ)  index of the requester being answered
rsp_id  out  ID_W  type ID
rsp_new  out  1  1 = entry allocated by this request
rsp_full  out  1  1 = table full, key not registered, rsp_id=0
clear  in  1  flush registry (level)
count  out  ID_W+1  number of registered entries
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous:
  - FSM=IDLE, count=0; all outputs 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
  - Table contents are don't-care; entries at index >= count are never compared.
- Handshake:
  - req_ready[i] is 1 for exactly one cycle, only in IDLE, for the granted i.
  - The key is latched that same cycle.
  - The requester holds req_valid/req_key until it sees req_ready.
  - req_valid dropped before grant is legal; the request is silently withdrawn.
- Arbitration:
  - Round robin, searching from last+1 upward with wrap.
  - last updates to the granted index on grant only.
- States:
  - IDLE:
    - If clear=1: count<=0; no grant that cycle (clear has priority).
    - Else if any req_valid: grant, key latched, idx<=0, go to SCAN.
  - SCAN, one entry per cycle:
    - idx<count and table[idx]==key: rsp_id=idx, rsp_new=0, go to RESP.
    - idx<count, no match: idx++.
    - idx==count and count<DEPTH: table[count]<=key, rsp_id=count, rsp_new=1, count++, go to RESP.
    - idx==count==DEPTH: rsp_full=1, rsp_id=0, rsp_new=0, go to RESP.
  - RESP:
    - rsp_valid=1; rsp_* stable.
    - On rsp_ready=1: outputs drop the next cycle, go to IDLE.
- Latency (grant in cycle 0):
  - Match at entry m: rsp_valid rises in cycle m+2.
  - Allocation or full: rsp_valid rises in cycle count+2.
  - Empty table: cycle 2.
  - Minimum grant-to-grant spacing is 4 cycles (grant, SCAN, RESP with rsp_ready=1, IDLE).
- count:
  - Updates in the allocation cycle and saturates at DEPTH.
  - IDs are never reused until clear.
- clear:
  - Sampled only in IDLE.
  - Asserted in SCAN/RESP, it has no effect until the FSM returns to IDLE with clear still high.
- Duplicate keys requested simultaneously by two requesters: the first grant allocates and the second gets the same ID with rsp_new=0.
- Reset mid-operation aborts the transaction: no response and no partial allocation; count=0.
- busy=1 in SCAN and RESP.

Test Plan:
- Empty table, req0 key 0xA5A5_0001 -> req_ready[0] in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_new=1, rsp_req=0; count=1.
- Repeat key 0xA5A5_0001 on req2 after three other keys have been registered (IDs 1..3) -> rsp_id=0, rsp_new=0, rsp_valid in cycle 2; count stays 4.
- All 4 requesters valid with distinct keys from reset -> grant order 0,1,2,3; IDs 0,1,2,3; then req1 and req3 valid again -> grant order 1,3.
- Register 16 keys, then a 17th new key -> rsp_full=1, rsp_id=0, rsp_valid in cycle 18; count=16; an existing key still hits correctly.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable and no req_ready pulses; rsp_ready=1 -> next grant 2 cycles later.
- clear=1 during SCAN -> no effect until IDLE; then count=0 and the next new key gets ID 0. rst_n low mid-SCAN -> no rsp_valid, count=0.
